// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//
// Input conditioner for the board slide switches and push buttons. Each raw
// asynchronous input bit is passed through a two-flop synchronizer and then
// debounced by its own stability counter. A new level is accepted only after
// the synchronized input has differed from the current debounced level for
// STABLE_CYCLES consecutive clocks. The block reports that change as a
// one-cycle rise or fall strobe.
//
// Ports:
//   CLK      system clock, all state changes on the rising edge
//   RST      asynchronous active-high reset
//   sw_in    [WIDTH]  raw asynchronous switch/button levels
//   sw_out   [WIDTH]  debounced level (registered)
//   rise     [WIDTH]  one-cycle strobe when sw_out[i] goes 0->1
//   fall     [WIDTH]  one-cycle strobe when sw_out[i] goes 1->0
//   changed  [1]      registered OR of all rise/fall bits, same cycle as strobes
// -----------------------------------------------------------------------------
module sw_debounce #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // The counter only has to reach STABLE_CYCLES-1, so clog2 is enough.
    // Keep at least one bit so the STABLE_CYCLES=1 build still elaborates.
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;
    logic             changed_reg;

    // Two-flop synchronizer. Nothing else reads sw_in.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= sw_in;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             out_reg;
            logic             out_next;
            logic             rise_reg;
            logic             fall_reg;
            logic             rise_bit_next;
            logic             fall_bit_next;

            // Each bit is a two-state FSM: it is STABLE when sync2 matches
            // out, and SETTLING otherwise. The counter measures how long the
            // bit has been SETTLING. Any return to the accepted level throws
            // away the progress. This rejects glitches shorter than the window.
            always_comb begin
                cnt_next      = cnt_reg;
                out_next      = out_reg;
                rise_bit_next = 1'b0;
                fall_bit_next = 1'b0;
                if (sync2_reg[gi] == out_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    out_next      = sync2_reg[gi];
                    cnt_next      = '0;
                    rise_bit_next = sync2_reg[gi];
                    fall_bit_next = ~sync2_reg[gi];
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    cnt_reg  <= '0;
                    out_reg  <= 1'b0;
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    out_reg  <= out_next;
                    rise_reg <= rise_bit_next;
                    fall_reg <= fall_bit_next;
                end
            end

            assign rise_next[gi] = rise_bit_next;
            assign fall_next[gi] = fall_bit_next;
            assign sw_out[gi]    = out_reg;
            assign rise[gi]      = rise_reg;
            assign fall[gi]      = fall_reg;
        end
    endgenerate

    // changed is built from the next-state strobes. That way it is
    // registered in the same cycle as the strobes instead of one cycle later.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            changed_reg <= 1'b0;
        end else begin
            changed_reg <= |(rise_next | fall_next);
        end
    end

    assign changed = changed_reg;

endmodule
